// File: rtl/cpu_mem_seq.sv
// Multi-byte little-endian load/store sequencer between the 65c816 core and the memory bus.
// Runs one req/ack bus cycle per byte with linear, bank or page address wrap and an optional ack timeout.
module cpu_mem_seq #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES  = 3,
  parameter int TIMEOUT    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            start,
  input  logic                            start_write,
  input  logic [2:0]                      start_len,
  input  logic [ADDR_WIDTH-1:0]           start_addr,
  input  logic [1:0]                      start_wrap,
  input  logic [MAX_BYTES*DATA_WIDTH-1:0] start_wdata,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [MAX_BYTES*DATA_WIDTH-1:0] rdata,
  output logic                            req_rdwr,
  output logic                            which_rdwr,
  output logic [ADDR_WIDTH-1:0]           addr,
  output logic [DATA_WIDTH-1:0]           data_out,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            mem_ack
);

  localparam logic RDWR_READ  = 1'b0;
  localparam logic RDWR_WRITE = 1'b1;

  // Casting the masks to the address width makes bank wrap collapse to linear when ADDR_WIDTH is 16.
  localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(32'h0000_FFFF);
  localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(32'h0000_00FF);
  localparam logic [2:0]            LEN_MAX   = 3'(MAX_BYTES);
  localparam logic [31:0]           TO_LAST   = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t                          state;
  logic [2:0]                      idx;
  logic [2:0]                      op_len;
  logic [1:0]                      op_wrap;
  logic                            op_write;
  logic                            op_err;
  logic [MAX_BYTES*DATA_WIDTH-1:0] op_wdata;
  logic [31:0]                     tcnt;
  logic                            len_ok;
  logic                            last_byte;

  assign len_ok    = (start_len != 3'd0) && (start_len <= LEN_MAX);
  assign last_byte = (idx == op_len - 3'd1);

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] wrap);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc = a + ADDR_WIDTH'(1);
    case (wrap)
      2'b01:   mask = BANK_MASK;
      2'b10:   mask = PAGE_MASK;
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wbyte(input logic [MAX_BYTES*DATA_WIDTH-1:0] d,
                                                  input logic [2:0] n);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (n == 3'(i)) r = d[i*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      op_len     <= '0;
      op_wrap    <= '0;
      op_write   <= 1'b0;
      op_err     <= 1'b0;
      op_wdata   <= '0;
      tcnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      req_rdwr   <= 1'b0;
      which_rdwr <= RDWR_READ;
      addr       <= '0;
      data_out   <= '0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            op_write <= start_write;
            op_len   <= start_len;
            op_wrap  <= start_wrap;
            op_wdata <= start_wdata;
            idx      <= '0;
            tcnt     <= '0;
            if (len_ok) begin
              op_err     <= 1'b0;
              rdata      <= '0;
              req_rdwr   <= 1'b1;
              addr       <= start_addr;
              which_rdwr <= start_write ? RDWR_WRITE : RDWR_READ;
              data_out   <= start_write ? start_wdata[DATA_WIDTH-1:0] : '0;
              state      <= S_REQ;
            end else begin
              // Bad length skips the bus entirely and reports through the completion pulse.
              op_err <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            tcnt <= '0;
            for (int i = 0; i < MAX_BYTES; i++) begin
              if (!op_write && idx == 3'(i)) rdata[i*DATA_WIDTH +: DATA_WIDTH] <= data_in;
            end
            if (last_byte) begin
              req_rdwr <= 1'b0;
              state    <= S_DONE;
            end else begin
              idx  <= idx + 3'd1;
              addr <= next_addr(addr, op_wrap);
              if (op_write) data_out <= wbyte(op_wdata, idx + 3'd1);
            end
          end else if (TIMEOUT > 0) begin
            if (tcnt == TO_LAST) begin
              req_rdwr <= 1'b0;
              op_err   <= 1'b1;
              state    <= S_DONE;
            end else begin
              tcnt <= tcnt + 32'd1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          err   <= op_err;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_seq.sv
// Scoreboard bench for cpu_mem_seq: stimulus pushes expected bus beats and completions,
// a monitor compares them against the DUT, and a responder models memory with random ack delays.
module tb_cpu_mem_seq;

  localparam int AW = 24;
  localparam int DW = 8;
  localparam int MB = 3;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             start;
  logic             start_write;
  logic [2:0]       start_len;
  logic [AW-1:0]    start_addr;
  logic [1:0]       start_wrap;
  logic [MB*DW-1:0] start_wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [MB*DW-1:0] rdata;
  logic             req_rdwr;
  logic             which_rdwr;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    data_out;
  logic [DW-1:0]    data_in = '0;
  logic             mem_ack = 1'b0;

  typedef struct {
    logic [AW-1:0] a;
    logic          wr;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    logic             err;
    logic             chk_rdata;
    logic [MB*DW-1:0] rdata;
    longint           done_cyc;
  } cmp_t;

  beat_t      beat_q[$];
  cmp_t       cmp_q[$];
  logic [7:0] mem[int unsigned];

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  int     done_count = 0;
  int     dly_min = 0;
  int     dly_max = 0;
  int     ack_budget = -1;
  int     beat_wait = -1;
  bit     beat_taken = 1'b0;
  bit     mon_en = 1'b0;

  cpu_mem_seq #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_BYTES (MB),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .start_write(start_write),
    .start_len  (start_len),
    .start_addr (start_addr),
    .start_wrap (start_wrap),
    .start_wdata(start_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .req_rdwr   (req_rdwr),
    .which_rdwr (which_rdwr),
    .addr       (addr),
    .data_out   (data_out),
    .data_in    (data_in),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_rd(input int unsigned a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  // Reference address stepping, written as plain modular arithmetic.
  function automatic longint model_next(input longint a, input logic [1:0] wrap);
    case (wrap)
      2'b01:   return (a / 65536) * 65536 + (a % 65536 + 1) % 65536;
      2'b10:   return (a / 256) * 256 + (a % 256 + 1) % 256;
      default: return (a + 1) % (longint'(1) << AW);
    endcase
  endfunction

  // Memory responder: acks each requested byte after a random number of cycles.
  always @(negedge clk) begin
    if (beat_taken) begin
      beat_wait  = -1;
      beat_taken = 1'b0;
    end
    if (rst || !req_rdwr || ack_budget == 0) begin
      mem_ack   = 1'b0;
      beat_wait = -1;
    end else begin
      if (beat_wait < 0) beat_wait = int'($urandom_range(dly_max, dly_min));
      if (beat_wait == 0) begin
        mem_ack = 1'b1;
        data_in = mem_rd(32'(addr));
      end else begin
        mem_ack = 1'b0;
        data_in = 8'($urandom);
        beat_wait--;
      end
    end
  end

  // Monitor: samples just before each rising edge and checks against the scoreboard queues.
  always @(negedge clk) begin : monitor
    cmp_t c;
    #4;
    if (!rst && mon_en) begin
      if (req_rdwr) begin
        if (beat_q.size() == 0) begin
          checkOutput("unexpected_req", 64'(req_rdwr), 64'd0);
        end else begin
          checkOutput("bus_addr", 64'(addr), 64'(beat_q[0].a));
          checkOutput("bus_dir", 64'(which_rdwr), 64'(beat_q[0].wr));
          if (beat_q[0].wr) checkOutput("bus_wdata", 64'(data_out), 64'(beat_q[0].d));
          if (mem_ack && enable) begin
            beat_q.delete(0);
            beat_taken = 1'b1;
            if (ack_budget > 0) ack_budget--;
          end
        end
      end
      if (done && enable) begin
        if (cmp_q.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          c = cmp_q.pop_front();
          checkOutput("done_err", 64'(err), 64'(c.err));
          checkOutput("busy_at_done", 64'(busy), 64'd0);
          if (c.chk_rdata) checkOutput("rdata", 64'(rdata), 64'(c.rdata));
          if (c.done_cyc >= 0) checkOutput("done_cycle", 64'(cyc), 64'(c.done_cyc));
          if (c.err) beat_q.delete();
          else if (beat_q.size() != 0) checkOutput("beats_left", 64'(beat_q.size()), 64'd0);
        end
        done_count++;
      end
    end
  end

  task automatic applyStimulus(input logic wr, input int len, input logic [AW-1:0] a0,
                               input logic [1:0] wrap, input logic [MB*DW-1:0] wd,
                               input bit lat_chk, input bit rand_en, input bit poke,
                               input int pause_after);
    cmp_t   c;
    beat_t  b;
    longint a;
    longint start_cyc;
    int     lat;
    int     d0;
    bit     valid;
    valid       = (len >= 1) && (len <= MB);
    a           = longint'(a0);
    c.rdata     = '0;
    c.err       = !valid;
    c.chk_rdata = valid;
    lat         = 1;
    if (valid) begin
      for (int i = 0; i < len; i++) begin
        b.a  = AW'(a);
        b.wr = wr;
        b.d  = wr ? wd[i*DW +: DW] : '0;
        if (ack_budget < 0 || i < ack_budget) begin
          if (wr) mem[32'(a)] = wd[i*DW +: DW];
          else c.rdata[i*DW +: DW] = mem_rd(32'(a));
        end
        beat_q.push_back(b);
        a = model_next(a, wrap);
      end
      if (ack_budget >= 0 && ack_budget < len) begin
        c.err = 1'b1;
        lat   = ack_budget + TO + 1;
      end else begin
        lat = len * (dly_min + 1) + 1;
      end
      if (pause_after >= 0) lat += 5;
    end
    @(negedge clk);
    enable      = 1'b1;
    start       = 1'b1;
    start_write = wr;
    start_len   = 3'(len);
    start_addr  = a0;
    start_wrap  = wrap;
    start_wdata = wd;
    start_cyc   = cyc + 1;
    c.done_cyc  = lat_chk ? start_cyc + lat : -1;
    cmp_q.push_back(c);
    d0 = done_count;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      start       = 1'b1;
      start_write = ~wr;
      start_len   = 3'd1;
      start_addr  = a0 ^ 24'h5A5A5A;
    end
    for (int k = 0; k < 400 && done_count == d0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (pause_after >= 0 && k >= pause_after && k < pause_after + 5) enable = 1'b0;
      else if (rand_en) enable = ($urandom_range(0, 3) != 0);
      else enable = 1'b1;
    end
    enable = 1'b1;
    if (done_count == d0) begin
      checkOutput("op_completed", 64'(done_count - d0), 64'd1);
      beat_q.delete();
      cmp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lsel;
    int len;
    rst         = 1'b1;
    enable      = 1'b0;
    start       = 1'b0;
    start_write = 1'b0;
    start_len   = '0;
    start_addr  = '0;
    start_wrap  = '0;
    start_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_req", 64'(req_rdwr), 64'd0);
    checkOutput("rst_which", 64'(which_rdwr), 64'd0);
    checkOutput("rst_addr", 64'(addr), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    rst    = 1'b0;
    enable = 1'b1;
    mon_en = 1'b1;

    $display("[TB] load across linear carry");
    mem[32'h00FFFF] = 8'hAB;
    mem[32'h010000] = 8'hCD;
    applyStimulus(1'b0, 2, 24'h00FFFF, 2'b00, '0, 1'b1, 1'b0, 1'b0, -1);
    checkOutput("t1_rdata", 64'(rdata), 64'h00CDAB);

    $display("[TB] store with bank wrap");
    applyStimulus(1'b1, 3, 24'h12FFFF, 2'b01, 24'h332211, 1'b1, 1'b0, 1'b0, -1);
    checkOutput("t2_rdata_zero", 64'(rdata), 64'd0);

    $display("[TB] load with page wrap and slow acks");
    dly_min = 3;
    dly_max = 3;
    applyStimulus(1'b0, 2, 24'h0345FF, 2'b10, '0, 1'b1, 1'b0, 1'b1, -1);
    dly_min = 0;
    dly_max = 0;

    $display("[TB] timeouts and bad lengths");
    ack_budget = 0;
    applyStimulus(1'b0, 2, 24'h004000, 2'b00, '0, 1'b1, 1'b0, 1'b0, -1);
    ack_budget = 1;
    applyStimulus(1'b0, 3, 24'h0050FE, 2'b00, '0, 1'b1, 1'b0, 1'b0, -1);
    ack_budget = -1;
    applyStimulus(1'b0, 0, 24'h001234, 2'b00, '0, 1'b1, 1'b0, 1'b0, -1);
    applyStimulus(1'b1, 4, 24'h001234, 2'b00, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, -1);

    $display("[TB] reset during store");
    mon_en  = 1'b0;
    dly_min = 2;
    dly_max = 2;
    @(negedge clk);
    start       = 1'b1;
    start_write = 1'b1;
    start_len   = 3'd3;
    start_addr  = 24'h200000;
    start_wrap  = 2'b00;
    start_wdata = 24'hC0FFEE;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_req", 64'(req_rdwr), 64'd0);
    checkOutput("mid_rst_addr", 64'(addr), 64'd0);
    checkOutput("mid_rst_wdata", 64'(data_out), 64'd0);
    checkOutput("mid_rst_which", 64'(which_rdwr), 64'd0);
    beat_q.delete();
    cmp_q.delete();
    @(negedge clk);
    rst     = 1'b0;
    dly_min = 0;
    dly_max = 0;
    mon_en  = 1'b1;
    applyStimulus(1'b1, 3, 24'hFFFFFE, 2'b00, 24'h665544, 1'b1, 1'b0, 1'b0, -1);

    $display("[TB] enable held low during load");
    applyStimulus(1'b0, 3, 24'h12FFFE, 2'b00, '0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 3, 24'h12FFFE, 2'b01, '0, 1'b1, 1'b0, 1'b0, -1);

    $display("[TB] random operations");
    dly_min = 0;
    dly_max = 3;
    for (int n = 0; n < 40; n++) begin
      lsel = int'($urandom_range(0, 9));
      if (lsel == 0) len = ($urandom_range(0, 1) == 0) ? 0 : 4;
      else len = int'($urandom_range(1, MB));
      applyStimulus(1'($urandom_range(0, 1)), len, AW'($urandom), 2'($urandom_range(0, 3)),
                    (MB*DW)'($urandom), 1'b0, 1'b1, 1'b0, -1);
    end
    checkOutput("pending_completions", 64'(cmp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
